// File: rtl/parc_mem_arbiter.sv
// Round-robin merge of the core's imem/dmem val/rdy request ports onto one memory port,
// with an in-order owner queue steering responses back. Optional counters: PARC_MEM_ARB_STATS_EN.
module parc_mem_arbiter #(
  parameter int p_depth     = 4,
  parameter int p_cnt_nbits = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] imemreq_msg,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  output logic [34:0] imemresp_msg,
  output logic        imemresp_val,
  input  logic [66:0] dmemreq_msg,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  output logic [34:0] dmemresp_msg,
  output logic        dmemresp_val,
  output logic [66:0] memreq_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic [34:0] memresp_msg,
  input  logic        memresp_val
`ifdef PARC_MEM_ARB_STATS_EN
  ,
  output logic [31:0] imem_grant_cnt,
  output logic [31:0] dmem_grant_cnt,
  output logic [31:0] conflict_cnt
`endif
);

  localparam int PTR_W = p_cnt_nbits - 1;

  // Handshake: a transfer happens on a port in any cycle where its val and rdy are both
  // high; the memory response side has no rdy and is consumed in the cycle it is valid.

  logic [p_depth-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [p_cnt_nbits-1:0] count_q, count_d;
  logic                   prio_q, prio_d;

  logic grant_imem, grant_dmem;
  logic full, empty, issue, pop, head_owner;

  always_comb begin
    full  = (count_q == p_cnt_nbits'(p_depth));
    empty = (count_q == '0);

    // Grant depends only on the vals and prio, never on any rdy.
    grant_imem = imemreq_val & (~dmemreq_val | ~prio_q);
    grant_dmem = dmemreq_val & (~imemreq_val | prio_q);

    memreq_val  = (imemreq_val | dmemreq_val) & ~full;
    memreq_msg  = grant_dmem ? dmemreq_msg : imemreq_msg;
    imemreq_rdy = grant_imem & memreq_rdy & ~full;
    dmemreq_rdy = grant_dmem & memreq_rdy & ~full;

    issue      = memreq_val & memreq_rdy;
    pop        = memresp_val & ~empty;
    head_owner = owner_q[head_q];

    imemresp_msg = memresp_msg;
    dmemresp_msg = memresp_msg;
    imemresp_val = pop & ~head_owner;
    dmemresp_val = pop & head_owner;

    owner_d = owner_q;
    tail_d  = tail_q;
    head_d  = head_q;
    count_d = count_q;
    prio_d  = prio_q;

    if (issue) begin
      owner_d[tail_q] = grant_dmem;
      tail_d          = tail_q + PTR_W'(1);
      prio_d          = ~grant_dmem;
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (issue && !pop) begin
      count_d = count_q + p_cnt_nbits'(1);
    end else if (!issue && pop) begin
      count_d = count_q - p_cnt_nbits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      prio_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      prio_q  <= prio_d;
    end
  end

`ifdef PARC_MEM_ARB_STATS_EN
  logic [31:0] imem_grant_cnt_q, imem_grant_cnt_d;
  logic [31:0] dmem_grant_cnt_q, dmem_grant_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    imem_grant_cnt_d = imem_grant_cnt_q;
    dmem_grant_cnt_d = dmem_grant_cnt_q;
    conflict_cnt_d   = conflict_cnt_q;
    if (issue && !grant_dmem) imem_grant_cnt_d = imem_grant_cnt_q + 32'd1;
    if (issue && grant_dmem)  dmem_grant_cnt_d = dmem_grant_cnt_q + 32'd1;
    if (imemreq_val && dmemreq_val && memreq_rdy && !full) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_grant_cnt_q <= '0;
      dmem_grant_cnt_q <= '0;
      conflict_cnt_q   <= '0;
    end else begin
      imem_grant_cnt_q <= imem_grant_cnt_d;
      dmem_grant_cnt_q <= dmem_grant_cnt_d;
      conflict_cnt_q   <= conflict_cnt_d;
    end
  end

  assign imem_grant_cnt = imem_grant_cnt_q;
  assign dmem_grant_cnt = dmem_grant_cnt_q;
  assign conflict_cnt   = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_parc_mem_arbiter.sv
// Directed, table-driven bench for parc_mem_arbiter: one vector per clock cycle.
module tb_parc_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [66:0] imemreq_msg, dmemreq_msg, memreq_msg;
  logic        imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic [34:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic        imemresp_val, dmemresp_val;
  logic        memreq_val, memreq_rdy, memresp_val;
`ifdef PARC_MEM_ARB_STATS_EN
  logic [31:0] imem_grant_cnt, dmem_grant_cnt, conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  parc_mem_arbiter #(.p_depth(4), .p_cnt_nbits(3)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val)
`ifdef PARC_MEM_ARB_STATS_EN
    ,
    .imem_grant_cnt(imem_grant_cnt), .dmem_grant_cnt(dmem_grant_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv, dv, mrdy, rv;
    logic [31:0] data;
    logic        e_irdy, e_drdy, e_mval, e_sel_d, e_irv, e_drv;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic iv, dv, mrdy, rv, input logic [31:0] data,
                              input logic irdy, drdy, mval, sel_d, irv, drv);
    vec_t v;
    v.iv = iv; v.dv = dv; v.mrdy = mrdy; v.rv = rv; v.data = data;
    v.e_irdy = irdy; v.e_drdy = drdy; v.e_mval = mval; v.e_sel_d = sel_d;
    v.e_irv = irv; v.e_drv = drv;
    return v;
  endfunction

  function automatic logic [66:0] mk_req(input logic [31:0] addr);
    return {1'b0, addr, 2'b00, 32'h0};
  endfunction

  function automatic logic [34:0] mk_resp(input logic [31:0] data);
    return {1'b0, 2'b00, data};
  endfunction

  task automatic check(input string name, input int idx, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Driver: drive one cycle at the falling edge, check combinational outputs 1ns later.
  task automatic apply(input int idx, input vec_t v);
    logic [66:0] ireq, dreq;
    @(negedge clk);
    ireq = mk_req(32'h1000 + 32'(idx) * 32'h4);
    dreq = mk_req(32'h2000 + 32'(idx) * 32'h4);
    imemreq_val = v.iv;  imemreq_msg = ireq;
    dmemreq_val = v.dv;  dmemreq_msg = dreq;
    memreq_rdy  = v.mrdy;
    memresp_val = v.rv;  memresp_msg = mk_resp(v.data);
    #1;
    check("imemreq_rdy", idx, 67'(imemreq_rdy), 67'(v.e_irdy));
    check("dmemreq_rdy", idx, 67'(dmemreq_rdy), 67'(v.e_drdy));
    check("memreq_val", idx, 67'(memreq_val), 67'(v.e_mval));
    if (v.e_mval) check("memreq_msg", idx, memreq_msg, v.e_sel_d ? dreq : ireq);
    check("imemresp_val", idx, 67'(imemresp_val), 67'(v.e_irv));
    check("dmemresp_val", idx, 67'(dmemresp_val), 67'(v.e_drv));
    if (v.e_irv) check("imemresp_msg", idx, 67'(imemresp_msg), 67'(mk_resp(v.data)));
    if (v.e_drv) check("dmemresp_msg", idx, 67'(dmemresp_msg), 67'(mk_resp(v.data)));
  endtask

  initial begin
    //              iv dv rdy rv data           irdy drdy mval seld irv drv
    // single imem read at 0x1000
    vecs[0]  = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 1, 32'hDEADBEEF,   0, 0, 0, 0, 1, 0);
    // both valid for 4 cycles: dmem, imem, dmem, imem; responses overlap issue
    vecs[2]  = mk(1, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
    vecs[3]  = mk(1, 1, 1, 1, 32'h11,         1, 0, 1, 0, 0, 1);
    vecs[4]  = mk(1, 1, 1, 1, 32'h12,         0, 1, 1, 1, 1, 0);
    vecs[5]  = mk(1, 1, 1, 1, 32'h13,         1, 0, 1, 0, 0, 1);
    vecs[6]  = mk(0, 0, 1, 1, 32'h14,         0, 0, 0, 0, 1, 0);
    // fill the queue with imem requests, then full blocks issue despite a pop
    vecs[7]  = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[8]  = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[11] = mk(1, 0, 1, 1, 32'h21,         0, 0, 0, 0, 1, 0);
    vecs[12] = mk(1, 0, 1, 1, 32'h22,         1, 0, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 1, 1, 32'h23,         0, 0, 0, 0, 1, 0);
    vecs[14] = mk(0, 0, 1, 1, 32'h24,         0, 0, 0, 0, 1, 0);
    vecs[15] = mk(0, 0, 1, 1, 32'h25,         0, 0, 0, 0, 1, 0);
    // interleaved owners imem, dmem, dmem, imem
    vecs[16] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
    vecs[18] = mk(0, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
    vecs[19] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 32'h1,          0, 0, 0, 0, 1, 0);
    vecs[21] = mk(0, 0, 1, 1, 32'h2,          0, 0, 0, 0, 0, 1);
    vecs[22] = mk(0, 0, 1, 1, 32'h3,          0, 0, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 1, 1, 32'h4,          0, 0, 0, 0, 1, 0);
    // response while empty is dropped; count must stay at zero
    vecs[24] = mk(0, 0, 1, 1, 32'h55,         0, 0, 0, 0, 0, 0);
    vecs[25] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
    vecs[26] = mk(0, 0, 1, 1, 32'h66,         0, 0, 0, 0, 1, 0);
    // memory stalled: grant shown, no rdy, prio unchanged
    vecs[27] = mk(1, 1, 0, 0, 32'h0,          0, 0, 1, 1, 0, 0);
    vecs[28] = mk(1, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
    vecs[29] = mk(0, 0, 1, 1, 32'h77,         0, 0, 0, 0, 0, 1);

    reset = 1'b1;
    imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 1; memresp_val = 0;
    imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
    repeat (2) @(negedge clk);
    // reset state: outputs quiet, stray response under reset dropped
    apply(100, mk(0, 0, 1, 1, 32'h99, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // reset with three requests outstanding and prio pointing at imem
    apply(200, mk(0, 1, 1, 0, 32'h0, 0, 1, 1, 1, 0, 0));
    apply(201, mk(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 0));
    apply(202, mk(0, 1, 1, 0, 32'h0, 0, 1, 1, 1, 0, 0));
    reset = 1'b1;
    apply(203, mk(0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    apply(204, mk(0, 0, 1, 1, 32'hABC, 0, 0, 0, 0, 0, 0));
    apply(205, mk(1, 1, 1, 0, 32'h0,   0, 1, 1, 1, 0, 0));
    apply(206, mk(1, 0, 1, 1, 32'hBCD, 1, 0, 1, 0, 0, 1));
    apply(207, mk(0, 0, 1, 1, 32'hCDE, 0, 0, 0, 0, 1, 0));

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
